// File: rtl/morsecode_decoder.sv
// Receiver for the A..H Morse light link: classifies marks and assembles up to 4 elements.
// It emits a 3-bit letter code or an error pulse. Optional macro MORSE_DASH_TOL_EN widens the dash window.
module morsecode_decoder #(
  parameter int unsigned DASH_UNITS       = 3,
  parameter int unsigned LETTER_GAP_UNITS = 3,
  parameter int unsigned RUN_W            = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       unit_tick,
  input  logic       morse_in,
  output logic [2:0] letter_out,
  output logic       letter_valid,
  output logic       letter_error,
  output logic       busy
);

  localparam int unsigned CNT_W  = 3;
  localparam int unsigned PAT_W  = 4;
  localparam int unsigned CODE_W = 3;

  localparam logic [RUN_W-1:0] RUN_MAX  = '1;
  localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);
  localparam logic [RUN_W-1:0] DASH_LEN = RUN_W'(DASH_UNITS);
  localparam logic [RUN_W-1:0] GAP_LEN  = RUN_W'(LETTER_GAP_UNITS);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(PAT_W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MARK  = 2'd1,
    SPACE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [RUN_W-1:0]    run_q, run_d, run_inc;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PAT_W-1:0]    pat_q, pat_d;
  logic                bad_q, bad_d;
  logic                ovf_q, ovf_d;
  logic [CODE_W-1:0]   letter_q, letter_d;
  logic                valid_q, valid_d;
  logic                error_q, error_d;
  logic                busy_q, busy_d;
  logic                is_dot, is_dash;
  logic                lut_hit;
  logic [CODE_W-1:0]   lut_code;

  assign run_inc = (run_q == RUN_MAX) ? run_q : run_q + RUN_ONE;

  // Mark classification; a single unit is always a dot, even inside the dash window.
  always_comb begin
    is_dot = (run_q == RUN_ONE);
`ifdef MORSE_DASH_TOL_EN
    is_dash = !is_dot && (run_q >= DASH_LEN - RUN_ONE) && (run_q <= DASH_LEN + RUN_ONE);
`else
    is_dash = !is_dot && (run_q == DASH_LEN);
`endif
  end

  // Letter table keyed on element count plus pattern (first element in bit 0, dash = 1).
  always_comb begin
    lut_hit  = 1'b1;
    lut_code = '0;
    case ({cnt_q, pat_q})
      {3'd2, 4'b0010}: lut_code = 3'd0;
      {3'd4, 4'b0001}: lut_code = 3'd1;
      {3'd4, 4'b0101}: lut_code = 3'd2;
      {3'd3, 4'b0001}: lut_code = 3'd3;
      {3'd1, 4'b0000}: lut_code = 3'd4;
      {3'd4, 4'b0100}: lut_code = 3'd5;
      {3'd3, 4'b0011}: lut_code = 3'd6;
      {3'd4, 4'b0000}: lut_code = 3'd7;
      default:         lut_hit  = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    run_d    = run_q;
    cnt_d    = cnt_q;
    pat_d    = pat_q;
    bad_d    = bad_q;
    ovf_d    = ovf_q;
    letter_d = letter_q;
    valid_d  = 1'b0;
    error_d  = 1'b0;
    busy_d   = busy_q;
    if (unit_tick) begin
      case (state_q)
        IDLE: begin
          if (morse_in) begin
            state_d = MARK;
            run_d   = RUN_ONE;
            busy_d  = 1'b1;
          end
        end
        MARK: begin
          if (morse_in) begin
            run_d = run_inc;
          end else begin
            if (cnt_q == CNT_FULL) begin
              ovf_d = 1'b1;
            end else if (is_dot || is_dash) begin
              pat_d[cnt_q[1:0]] = is_dash;
              cnt_d = cnt_q + CNT_W'(1);
            end else begin
              bad_d = 1'b1;
            end
            state_d = SPACE;
            run_d   = RUN_ONE;
          end
        end
        SPACE: begin
          if (morse_in) begin
            state_d = MARK;
            run_d   = RUN_ONE;
          end else begin
            run_d = run_inc;
            // Letter end resolves on the same tick that completes the gap.
            if (run_inc >= GAP_LEN) begin
              if (bad_q || ovf_q || !lut_hit) begin
                error_d = 1'b1;
              end else begin
                letter_d = lut_code;
                valid_d  = 1'b1;
              end
              state_d = IDLE;
              run_d   = '0;
              cnt_d   = '0;
              pat_d   = '0;
              bad_d   = 1'b0;
              ovf_d   = 1'b0;
              busy_d  = 1'b0;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      run_q    <= '0;
      cnt_q    <= '0;
      pat_q    <= '0;
      bad_q    <= 1'b0;
      ovf_q    <= 1'b0;
      letter_q <= '0;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      run_q    <= run_d;
      cnt_q    <= cnt_d;
      pat_q    <= pat_d;
      bad_q    <= bad_d;
      ovf_q    <= ovf_d;
      letter_q <= letter_d;
      valid_q  <= valid_d;
      error_q  <= error_d;
      busy_q   <= busy_d;
    end
  end

  assign letter_out   = letter_q;
  assign letter_valid = valid_q;
  assign letter_error = error_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_morsecode_decoder.sv
// Scoreboard bench for morsecode_decoder: expected letters/errors are queued as units are sent.
// Each pulse the decoder produces is then popped from the queue and compared.
module tb_morsecode_decoder;

  logic       clk;
  logic       rst_n;
  logic       unit_tick;
  logic       morse_in;
  logic [2:0] letter_out;
  logic       letter_valid;
  logic       letter_error;
  logic       busy;

  typedef struct packed {
    logic       is_err;
    logic [2:0] code;
  } exp_t;

  exp_t       sb_q[$];
  logic [2:0] held_code;
  int         n_checks;
  int         n_errors;

  morsecode_decoder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .unit_tick    (unit_tick),
    .morse_in     (morse_in),
    .letter_out   (letter_out),
    .letter_valid (letter_valid),
    .letter_error (letter_error),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_letter(input logic [2:0] code);
    sb_q.push_back({1'b0, code});
  endtask

  task automatic expect_error();
    sb_q.push_back({1'b1, 3'd0});
  endtask

  // One unit_tick with the given level, then max_gap-bounded idle clocks with the line wiggling.
  task automatic send_unit(input logic v, input int gap);
    morse_in  = v;
    unit_tick = 1'b1;
    @(posedge clk); #1;
    unit_tick = 1'b0;
    repeat (gap) begin
      morse_in = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
  endtask

  task automatic send_bits(input string s, input int max_gap);
    for (int i = 0; i < s.len(); i++) begin
      send_unit(s[i] == "1", (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
    end
  endtask

  // Pulse monitor: pops the scoreboard on every valid/error pulse.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst_n) begin
      held_code = 3'd0;
    end else begin
      if (letter_valid && letter_error) check("pulse_overlap", 32'(1), 32'(0));
      if (letter_valid || letter_error) begin
        if (sb_q.size() == 0) begin
          check("unexpected_pulse", 32'({letter_valid, letter_error}), 32'(0));
        end else begin
          e = sb_q.pop_front();
          check("pulse_kind", 32'(letter_error), 32'(e.is_err));
          if (e.is_err) begin
            check("code_held_on_error", 32'(letter_out), 32'(held_code));
          end else begin
            check("letter_code", 32'(letter_out), 32'(e.code));
            held_code = e.code;
          end
        end
      end
    end
  end

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    held_code = 3'd0;
    rst_n     = 1'b0;
    unit_tick = 1'b0;
    morse_in  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_letter_out", 32'(letter_out), 32'(0));
    check("rst_valid", 32'(letter_valid), 32'(0));
    check("rst_error", 32'(letter_error), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Leading space, then "A" with busy tracking.
    send_bits("000", 0);
    check("idle_busy", 32'(busy), 32'(0));
    expect_letter(3'd0);
    send_bits("1", 0);
    check("busy_first_mark", 32'(busy), 32'(1));
    send_bits("0111000", 0);
    check("busy_after_A", 32'(busy), 32'(0));

    // "C" then "E", with trailing idle space producing nothing.
    expect_letter(3'd2);
    send_bits("11101011101000", 0);
    expect_letter(3'd4);
    send_bits("1000", 0);
    send_bits("00000", 0);

    // "A" with a two-unit element gap (still below the letter gap).
    expect_letter(3'd0);
    send_bits("100111000", 0);

    // Two-unit mark: bad without tolerance, lone dash "-" not in table with it.
    expect_error();
    send_bits("11000", 0);
    check("busy_after_error", 32'(busy), 32'(0));

    // "D" with four-unit dashes.
`ifdef MORSE_DASH_TOL_EN
    expect_letter(3'd3);
`else
    expect_error();
`endif
    send_bits("11110101000", 0);

    // Five dots: overflow, letter_out holds its previous value.
    expect_error();
    send_bits("101010101000", 0);

    // Continuous-on line saturates the run counter, then is rejected on release.
    send_bits("11111111111111111111", 0);
    check("busy_long_mark", 32'(busy), 32'(1));
    check("no_pulse_mid_mark", 32'(sb_q.size()), 32'(0));
    expect_error();
    send_bits("000", 0);

    // "H" with random idle clocks between ticks and the line toggling in between.
    expect_letter(3'd7);
    send_bits("1010101000", 5);
    repeat (4) @(posedge clk);
    #1;
    check("H_held", 32'(letter_out), 32'(3'd7));

    // Reset mid-"B" discards the partial letter.
    send_bits("111010", 0);
    rst_n = 1'b0;
    #1;
    check("midrst_letter_out", 32'(letter_out), 32'(0));
    check("midrst_busy", 32'(busy), 32'(0));
    check("midrst_valid", 32'(letter_valid), 32'(0));
    check("midrst_error", 32'(letter_error), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    expect_letter(3'd6);
    send_bits("111011101000", 0);
    check("busy_after_G", 32'(busy), 32'(0));

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
